// File: rtl/rv_pc_pkg.sv
// Shared definitions for the fetch PC generator.
// Contents:
//   pc_src_e - next-PC source, listed from highest to lowest priority
//   PC_INC4  - sequential increment for 4-byte instructions
//   PC_INC2  - sequential increment for compressed instructions
package rv_pc_pkg;

   typedef enum logic [2:0] {
      SRC_TRAP,
      SRC_REDIR,
      SRC_PEND,
      SRC_RAS,
      SRC_SEQ
   } pc_src_e;

   localparam int unsigned PC_INC4 = 4;
   localparam int unsigned PC_INC2 = 2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack used for return prediction.
// Ports:
//   CLK    in   clock
//   RST    in   synchronous active-high reset (clears pointer and count)
//   PUSH   in   write WDATA as the new top
//   POP    in   discard the top entry (ignored when empty)
//   FLUSH  in   drop all entries (count -> 0)
//   WDATA  in   return address to push
//   TOP    out  current top entry
//   EMPTY  out  count is zero
// A push on a full stack overwrites the oldest entry; the count saturates.
// A push together with a pop on a non-empty stack replaces the top in place.
module pc_ras
   import rv_pc_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            PUSH,
   input  logic            POP,
   input  logic            FLUSH,
   input  logic [XLEN-1:0] WDATA,
   output logic [XLEN-1:0] TOP,
   output logic            EMPTY
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   ptr;      // next free slot; top lives at ptr-1
   logic [PW-1:0]   top_idx;
   logic [PW:0]     count;
   logic            nonempty;
   logic            do_replace;
   logic            do_push;
   logic            do_pop;

   always_comb begin
      top_idx    = ptr - 1'b1;
      nonempty   = (count != '0);
      do_replace = !FLUSH && PUSH && POP && nonempty;
      do_push    = !FLUSH && PUSH && !do_replace;
      do_pop     = !FLUSH && POP && !PUSH && nonempty;
   end

   assign TOP   = mem[top_idx];
   assign EMPTY = !nonempty;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr   <= '0;
         count <= '0;
      end else if (FLUSH) begin
         count <= '0;
      end else if (do_push) begin
         ptr <= ptr + 1'b1;
         if (count != CNT_FULL)
            count <= count + 1'b1;
      end else if (do_pop) begin
         ptr   <= ptr - 1'b1;
         count <= count - 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read once it has been pushed.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (do_replace)
            mem[top_idx] <= WDATA;
         else if (do_push)
            mem[ptr] <= WDATA;
      end
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: holds PCF and picks the next PC by priority from
// trap, EX redirect, buffered redirect, RAS prediction or sequential.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   EN                 fetch advance (0 = stall)
//   INC2               current instruction is compressed (C_EXT=1 only)
//   TRAP_VALID/TARGET  trap redirect request and handler address
//   REDIR_VALID/TARGET mispredict redirect from EX
//   RAS_PUSH, RAS_POP  fetched instruction is a call / return
//   PCF                current fetch PC
//   PCPlusF            PCF + 4 (or + 2 for compressed), combinational
//   MISALIGN           last loaded target was misaligned
//   PEND_VALID         a redirect captured during a stall is waiting
//   RAS_EMPTY          return stack holds no entries
module pc_gen_unit
   import rv_pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     RAS_DEPTH    = 4,
   parameter bit              C_EXT        = 1'b0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            EN,
   input  logic            INC2,
   input  logic            TRAP_VALID,
   input  logic [XLEN-1:0] TRAP_TARGET,
   input  logic            REDIR_VALID,
   input  logic [XLEN-1:0] REDIR_TARGET,
   input  logic            RAS_PUSH,
   input  logic            RAS_POP,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlusF,
   output logic            MISALIGN,
   output logic            PEND_VALID,
   output logic            RAS_EMPTY
);

   localparam logic [XLEN-1:0] BIT0_CLR = {{(XLEN-1){1'b1}}, 1'b0};

   logic [XLEN-1:0] pcf_q;
   logic [XLEN-1:0] pend_target_q;
   logic            pend_valid_q;
   logic            pend_trap_q;
   logic            misalign_q;

   pc_src_e         src;
   logic [XLEN-1:0] sel_target;
   logic [XLEN-1:0] load_target;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] inc;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty;
   logic            trap_load;
   logic            misalign_next;
   logic            ras_push;
   logic            ras_pop;
   logic            ras_flush;

   assign inc     = (C_EXT && INC2) ? XLEN'(PC_INC2) : XLEN'(PC_INC4);
   assign PCPlusF = pcf_q + inc;

   always_comb begin
      src           = SRC_SEQ;
      sel_target    = '0;
      trap_load     = 1'b0;
      next_pc       = PCPlusF;
      misalign_next = 1'b0;

      if (TRAP_VALID) begin
         src        = SRC_TRAP;
         sel_target = TRAP_TARGET;
         trap_load  = 1'b1;
      end else if (REDIR_VALID) begin
         src        = SRC_REDIR;
         sel_target = REDIR_TARGET;
      end else if (pend_valid_q) begin
         src        = SRC_PEND;
         sel_target = pend_target_q;
         trap_load  = pend_trap_q;
      end else if (RAS_POP && !ras_empty) begin
         src = SRC_RAS;
      end

      load_target = sel_target & BIT0_CLR;

      case (src)
         SRC_TRAP, SRC_REDIR, SRC_PEND: begin
            next_pc       = load_target;
            misalign_next = C_EXT ? 1'b0 : load_target[1];
         end
         SRC_RAS: next_pc = ras_top;
         default: next_pc = PCPlusF;
      endcase

      // The stack only moves on cycles where it is (or could be) the source.
      ras_push  = EN && RAS_PUSH && (src == SRC_RAS || src == SRC_SEQ);
      ras_pop   = EN && (src == SRC_RAS);
      ras_flush = EN && trap_load;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pcf_q         <= RESET_VECTOR;
         misalign_q    <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_trap_q   <= 1'b0;
         pend_target_q <= '0;
      end else if (EN) begin
         pcf_q        <= next_pc;
         misalign_q   <= misalign_next;
         // Either the pending entry is consumed now or a live source superseded it.
         pend_valid_q <= 1'b0;
         pend_trap_q  <= 1'b0;
      end else begin
         if (TRAP_VALID) begin
            pend_target_q <= TRAP_TARGET;
            pend_trap_q   <= 1'b1;
            pend_valid_q  <= 1'b1;
         end else if (REDIR_VALID && !(pend_valid_q && pend_trap_q)) begin
            pend_target_q <= REDIR_TARGET;
            pend_trap_q   <= 1'b0;
            pend_valid_q  <= 1'b1;
         end
      end
   end

   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .CLK   (CLK),
      .RST   (RST),
      .PUSH  (ras_push),
      .POP   (ras_pop),
      .FLUSH (ras_flush),
      .WDATA (PCPlusF),
      .TOP   (ras_top),
      .EMPTY (ras_empty)
   );

   assign PCF        = pcf_q;
   assign MISALIGN   = misalign_q;
   assign PEND_VALID = pend_valid_q;
   assign RAS_EMPTY  = ras_empty;

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised successor to the single fetch-PC register. It holds the fetch PC and selects the next PC by priority from: trap vector, execute-stage redirect, a buffered (pending) redirect, a return-address-stack (RAS) prediction, or sequential increment. It sits at the head of the fetch stage and feeds the instruction memory address and the PC+inc value to the IF/ID register. A redirect that arrives while fetch is stalled is buffered so that it is never lost.

Parameters:
XLEN, 32, PC and target width.
RESET_VECTOR, 32'h0000_0000, PCF value after reset.
RAS_DEPTH, 4, number of RAS entries; power of two, minimum 2.
C_EXT, 0, 1 enables the 2-byte sequential increment and 2-byte alignment checks.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  fetch advance; 0 = stall.
INC2  input  1  current instruction is compressed; ignored when C_EXT=0.
TRAP_VALID  input  1  trap/exception redirect request.
TRAP_TARGET  input  XLEN  trap handler address.
REDIR_VALID  input  1  branch/jump mispredict redirect from EX.
REDIR_TARGET  input  XLEN  redirect address.
RAS_PUSH  input  1  fetched instruction is a call.
RAS_POP  input  1  fetched instruction is a return.
PCF  output  XLEN  current fetch PC.
PCPlusF  output  XLEN  PCF+4, or PCF+2 when C_EXT=1 and INC2=1; combinational.
MISALIGN  output  1  registered; set when the last loaded target was misaligned.
PEND_VALID  output  1  a buffered redirect is waiting.
RAS_EMPTY  output  1  RAS count is 0.

Behaviour:
- Reset (RST=1 at an edge): PCF=RESET_VECTOR, MISALIGN=0, PEND_VALID=0, pending target=0, RAS count=0, RAS pointer=0, RAS_EMPTY=1. RST overrides every other input.
- EN=1: PCF loads next_pc in the same edge (latency 1). Selection priority:
  - 1. TRAP_VALID selects TRAP_TARGET.
  - 2. REDIR_VALID selects REDIR_TARGET.
  - 3. PEND_VALID selects the pending target; PEND_VALID clears.
  - 4. RAS_POP with RAS not empty selects the top of the RAS.
  - 5. Otherwise PCPlusF.
- EN=0: PCF holds.
  - TRAP_VALID writes the pending buffer and marks it as a trap.
  - REDIR_VALID writes the pending buffer only if it is empty or holds a non-trap entry. The newer redirect replaces an older one; a trap is never overwritten by a redirect.
  - PEND_VALID=1 after the write.
  - When TRAP and REDIR are both valid in a stalled cycle, TRAP wins.
- Live TRAP or REDIR with EN=1 and PEND_VALID=1: the live source wins and the pending buffer is cleared.
- Target bit 0 is always forced to 0 before loading.
- MISALIGN: updated whenever a target is loaded (priorities 1-3).
  - C_EXT=0: MISALIGN = target[1].
  - C_EXT=1: MISALIGN = 0.
  - A sequential or RAS load clears MISALIGN.
- RAS (circular, RAS_DEPTH entries, pointer wraps modulo RAS_DEPTH). Operations happen only when EN=1 and the selected source is priority 4 or 5.
  - Push writes PCPlusF and increments count, saturating at RAS_DEPTH. A push on a full RAS overwrites the oldest entry.
  - Pop on a non-empty RAS decrements count.
  - Pop on an empty RAS is ignored and falls through to sequential.
  - Push and pop in the same cycle replace the top entry with PCPlusF; count is unchanged; next PC is the old top.
- A loaded trap (live or pending) clears the RAS count to 0. Redirects leave the RAS unchanged.
- Arithmetic is modulo 2^XLEN; PCF wraps from all-ones to 0 without a flag.

Decomposition:
- Shared package rv_pc_pkg:
  - next-PC source enum: SRC_TRAP, SRC_REDIR, SRC_PEND, SRC_RAS, SRC_SEQ.
  - constants PC_INC4=4 and PC_INC2=2.
- Sub-module pc_ras:
  - ports: CLK, RST, PUSH, POP, FLUSH, WDATA, TOP, EMPTY.
  - holds the storage array, pointer and count logic, including overflow and simultaneous push/pop.
- The top level holds PCF, the pending buffer, MISALIGN and the priority mux.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_1000, then EN=1 for 3 cycles -> PCF=1000, 1004, 1008, 100C. MISALIGN=0, RAS_EMPTY=1.
- EN=0, REDIR_VALID=1 with target 2000 for 1 cycle, then EN=1 two cycles later -> PCF holds and PEND_VALID=1 until EN rises. Next PCF=2000, PEND_VALID=0.
- EN=0, trap to 0x80 then redirect to 0x3000 on the next stalled cycle, then EN=1 -> PCF=0x80 (trap not overwritten), RAS count=0.
- Same cycle with EN=1: TRAP to 0x80 and REDIR to 0x4000 -> PCF=0x80.
- RAS_DEPTH=4, PCF=100: push 5 times at successive PCs 100-110, then pop 5 times -> pops return 114, 110, 10C, 108. Fifth pop on empty -> sequential. RAS_EMPTY=1 after the fourth pop.
- Redirect C_EXT=0 to 0x2002 -> PCF=0x2002, MISALIGN=1. Redirect C_EXT=1 to 0x2003 -> PCF=0x2002, MISALIGN=0. INC2=1 -> PCPlusF=0x2004.
